// File: rtl/ifu_fetch_q.sv
// Instruction fetch queue: issues req/gnt fetches at pc_i and buffers in-order responses for decode.
// rvalid->inst_valid_o takes 1 cycle (0 with `IFQ_BYPASS_EN); req drops once buffered+outstanding+discards reach DEPTH.
module ifu_fetch_q #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              pc_adv_o,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 2;
  localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);

  logic [CW-1:0]     count, outst, discard_cnt;
  logic [ADDR_W-1:0] addr_q      [DEPTH];
  logic [ADDR_W-1:0] data_addr_q [DEPTH];
  logic [DATA_W-1:0] data_inst_q [DEPTH];
  logic [PW-1:0]     a_wp, a_rp, d_wp, d_rp;

  logic [SW-1:0] occ;
  logic accept, rsp_take, rsp_drop, head_vld, byp, pop, pop_q, push;

  always_comb begin
    occ        = SW'(count) + SW'(outst) + SW'(discard_cnt);
    imem_req_o = rstn && !flush_i && (occ < SW'(DEPTH));
    accept     = imem_req_o && imem_gnt_i;
    rsp_drop   = imem_rvalid_i && (discard_cnt != '0);
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp_take   = imem_rvalid_i && (discard_cnt == '0) && (outst != '0);
    head_vld   = (count != '0);
`ifdef IFQ_BYPASS_EN
    byp        = rsp_take && !head_vld;
`else
    byp        = 1'b0;
`endif
    inst_valid_o = head_vld || byp;
    inst_o       = NOP;
    inst_addr_o  = '0;
    if (head_vld) begin
      inst_o      = data_inst_q[d_rp];
      inst_addr_o = data_addr_q[d_rp];
    end else if (byp) begin
      inst_o      = imem_rdata_i;
      inst_addr_o = addr_q[a_rp];
    end
    pop   = inst_valid_o && !hold_i && !flush_i;
    pop_q = pop && head_vld;
    // A bypassed response consumed in the same cycle never enters the buffer.
    push  = rsp_take && !(byp && pop);
    pc_adv_o    = accept;
    imem_addr_o = pc_i;
    empty_o     = (count == '0) && (outst == '0) && (discard_cnt == '0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count       <= '0;
      outst       <= '0;
      discard_cnt <= '0;
      a_wp        <= '0;
      a_rp        <= '0;
      d_wp        <= '0;
      d_rp        <= '0;
    end else if (flush_i) begin
      // Everything still in flight at the old pc must be absorbed later.
      count       <= '0;
      outst       <= '0;
      discard_cnt <= discard_cnt - CW'(rsp_drop) + outst - CW'(rsp_take);
      a_wp        <= '0;
      a_rp        <= '0;
      d_wp        <= '0;
      d_rp        <= '0;
    end else begin
      count       <= count + CW'(push) - CW'(pop_q);
      outst       <= outst + CW'(accept) - CW'(rsp_take);
      discard_cnt <= discard_cnt - CW'(rsp_drop);
      if (accept)   a_wp <= a_wp + PW'(1);
      if (rsp_take) a_rp <= a_rp + PW'(1);
      if (push)     d_wp <= d_wp + PW'(1);
      if (pop_q)    d_rp <= d_rp + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) addr_q[a_wp] <= pc_i;
    if (push && !flush_i) begin
      data_addr_q[d_wp] <= addr_q[a_rp];
      data_inst_q[d_wp] <= imem_rdata_i;
    end
  end

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rstn)
    !(imem_rvalid_i && (outst == '0) && (discard_cnt == '0)));

endmodule

// File: tb/tb_ifu_fetch_q.sv
// Directed bench for ifu_fetch_q (DEPTH=2); inputs change 1 time unit after posedge, outputs sampled at negedge.
module tb_ifu_fetch_q;
`ifdef IFQ_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] pc_i;
  logic        pc_adv_o, imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        flush_i, hold_i;
  logic        inst_valid_o;
  logic [31:0] inst_o, inst_addr_o;
  logic        empty_o;

  int errors = 0;
  int checks = 0;
  logic        adv_prev = 1'b0;
  logic        jmp_vld  = 1'b0;
  logic [31:0] jmp_pc   = '0;

  ifu_fetch_q #(.DEPTH(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rstn(rstn), .pc_i(pc_i), .pc_adv_o(pc_adv_o),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .flush_i(flush_i), .hold_i(hold_i), .inst_valid_o(inst_valid_o),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus; the pc stage advances by 4 only after an accepted fetch.
  task automatic cyc(input logic g, input logic rv, input logic [31:0] rd,
                     input logic h, input logic f);
    @(posedge clk);
    #1;
    if (adv_prev) pc_i = pc_i + 32'd4;
    if (jmp_vld) begin
      pc_i = jmp_pc;
      jmp_vld = 1'b0;
    end
    imem_gnt_i = g; imem_rvalid_i = rv; imem_rdata_i = rd; hold_i = h; flush_i = f;
    #4;
    adv_prev = pc_adv_o;
  endtask

  task automatic test_reset;
    rstn = 1'b0; pc_i = '0; imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = '0;
    flush_i = 0; hold_i = 0;
    #12;
    if (pc_adv_o !== 1'b0) begin errors++; $display("FAIL rst_pc_adv: got %b want 0", pc_adv_o); end
    checks++;
    if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", imem_req_o); end
    checks++;
    if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", inst_valid_o); end
    checks++;
    if (inst_o !== NOP) begin errors++; $display("FAIL rst_inst: got %h want %h", inst_o, NOP); end
    checks++;
    if (inst_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", inst_addr_o); end
    checks++;
    if (empty_o !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", empty_o); end
    checks++;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_fetch_stream;
    cyc(1, 0, 32'h0, 0, 0);
    if (pc_adv_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++;
      $display("FAIL s1_accept: got adv=%b addr=%h want 1/0", pc_adv_o, imem_addr_o); end
    checks++;
    cyc(1, 1, 32'hA000_0000, 1, 0);
    if (pc_adv_o !== 1'b1 || imem_addr_o !== 32'h4) begin errors++;
      $display("FAIL s2_accept: got adv=%b addr=%h want 1/4", pc_adv_o, imem_addr_o); end
    checks++;
    if (inst_valid_o !== BYP) begin errors++; $display("FAIL s2_latency: got %b want %b", inst_valid_o, BYP); end
    checks++;
    cyc(1, 1, 32'hA000_0004, 0, 0);
    if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0 || inst_o !== 32'hA000_0000) begin errors++;
      $display("FAIL s3_head: got v=%b a=%h d=%h want 1/0/a0000000", inst_valid_o, inst_addr_o, inst_o); end
    checks++;
    if (pc_adv_o !== 1'b0 || imem_req_o !== 1'b0) begin errors++;
      $display("FAIL s3_full: got adv=%b req=%b want 0/0", pc_adv_o, imem_req_o); end
    checks++;
    cyc(1, 0, 32'h0, 0, 0);
    if (inst_addr_o !== 32'h4 || inst_o !== 32'hA000_0004) begin errors++;
      $display("FAIL s4_head: got a=%h d=%h want 4/a0000004", inst_addr_o, inst_o); end
    checks++;
    if (pc_adv_o !== 1'b1 || imem_addr_o !== 32'h8) begin errors++;
      $display("FAIL s4_accept: got adv=%b addr=%h want 1/8", pc_adv_o, imem_addr_o); end
    checks++;
    cyc(0, 1, 32'hA000_0008, 1, 0);
    if (pc_adv_o !== 1'b0) begin errors++; $display("FAIL s5_nogrant: got %b want 0", pc_adv_o); end
    checks++;
    cyc(0, 0, 32'h0, 0, 0);
    if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h8 || inst_o !== 32'hA000_0008) begin errors++;
      $display("FAIL s6_head: got v=%b a=%h d=%h want 1/8/a0000008", inst_valid_o, inst_addr_o, inst_o); end
    checks++;
    cyc(0, 0, 32'h0, 0, 0);
    if (empty_o !== 1'b1 || inst_valid_o !== 1'b0 || inst_o !== NOP || inst_addr_o !== 32'h0) begin errors++;
      $display("FAIL s7_drained: got e=%b v=%b d=%h a=%h want 1/0/nop/0", empty_o, inst_valid_o, inst_o, inst_addr_o); end
    checks++;
  endtask

  task automatic test_hold_full;
    jmp_vld = 1'b1; jmp_pc = 32'h0;
    cyc(1, 0, 32'h0, 1, 0);
    cyc(1, 1, 32'hB000_0000, 1, 0);
    cyc(1, 1, 32'hB000_0004, 1, 0);
    cyc(1, 0, 32'h0, 1, 0);
    if (imem_req_o !== 1'b0 || pc_adv_o !== 1'b0) begin errors++;
      $display("FAIL h_full: got req=%b adv=%b want 0/0", imem_req_o, pc_adv_o); end
    checks++;
    if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h0 || empty_o !== 1'b0) begin errors++;
      $display("FAIL h_held: got v=%b a=%h e=%b want 1/0/0", inst_valid_o, inst_addr_o, empty_o); end
    checks++;
    cyc(1, 0, 32'h0, 0, 0);
    if (inst_addr_o !== 32'h0 || inst_o !== 32'hB000_0000 || imem_req_o !== 1'b0) begin errors++;
      $display("FAIL h_pop0: got a=%h d=%h req=%b want 0/b0000000/0", inst_addr_o, inst_o, imem_req_o); end
    checks++;
    cyc(1, 0, 32'h0, 0, 0);
    if (inst_addr_o !== 32'h4 || inst_o !== 32'hB000_0004) begin errors++;
      $display("FAIL h_pop4: got a=%h d=%h want 4/b0000004", inst_addr_o, inst_o); end
    checks++;
    if (imem_req_o !== 1'b1 || pc_adv_o !== 1'b1 || imem_addr_o !== 32'h8) begin errors++;
      $display("FAIL h_rereq: got req=%b adv=%b addr=%h want 1/1/8", imem_req_o, pc_adv_o, imem_addr_o); end
    checks++;
    cyc(0, 1, 32'hB000_0008, 1, 0);
    cyc(0, 0, 32'h0, 0, 0);
    if (inst_addr_o !== 32'h8 || inst_o !== 32'hB000_0008) begin errors++;
      $display("FAIL h_pop8: got a=%h d=%h want 8/b0000008", inst_addr_o, inst_o); end
    checks++;
    cyc(0, 0, 32'h0, 0, 0);
  endtask

  task automatic test_flush_outstanding;
    jmp_vld = 1'b1; jmp_pc = 32'h20;
    cyc(1, 0, 32'h0, 0, 0);
    cyc(1, 0, 32'h0, 0, 0);
    if (pc_adv_o !== 1'b1 || imem_addr_o !== 32'h24) begin errors++;
      $display("FAIL f_second: got adv=%b addr=%h want 1/24", pc_adv_o, imem_addr_o); end
    checks++;
    cyc(1, 0, 32'h0, 0, 1);
    if (imem_req_o !== 1'b0 || pc_adv_o !== 1'b0) begin errors++;
      $display("FAIL f_flushcyc: got req=%b adv=%b want 0/0", imem_req_o, pc_adv_o); end
    checks++;
    jmp_vld = 1'b1; jmp_pc = 32'h80;
    cyc(0, 1, 32'hDEAD_0020, 0, 0);
    if (inst_valid_o !== 1'b0 || imem_req_o !== 1'b0 || empty_o !== 1'b0) begin errors++;
      $display("FAIL f_drop1: got v=%b req=%b e=%b want 0/0/0", inst_valid_o, imem_req_o, empty_o); end
    checks++;
    cyc(1, 1, 32'hDEAD_0024, 0, 0);
    if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL f_drop2: got %b want 0", inst_valid_o); end
    checks++;
    if (pc_adv_o !== 1'b1 || imem_addr_o !== 32'h80) begin errors++;
      $display("FAIL f_newpc: got adv=%b addr=%h want 1/80", pc_adv_o, imem_addr_o); end
    checks++;
    cyc(0, 1, 32'hC000_0080, 1, 0);
    cyc(0, 0, 32'h0, 0, 0);
    if (inst_valid_o !== 1'b1 || inst_addr_o !== 32'h80 || inst_o !== 32'hC000_0080) begin errors++;
      $display("FAIL f_head80: got v=%b a=%h d=%h want 1/80/c0000080", inst_valid_o, inst_addr_o, inst_o); end
    checks++;
    cyc(0, 0, 32'h0, 0, 0);
    if (empty_o !== 1'b1) begin errors++; $display("FAIL f_empty: got %b want 1", empty_o); end
    checks++;
  endtask

  task automatic test_flush_with_rvalid;
    jmp_vld = 1'b1; jmp_pc = 32'h40;
    cyc(1, 0, 32'h0, 0, 0);
    cyc(0, 1, 32'hDEAD_0040, 0, 1);
    cyc(0, 0, 32'h0, 0, 0);
    if (empty_o !== 1'b1 || inst_valid_o !== 1'b0 || imem_req_o !== 1'b1) begin errors++;
      $display("FAIL r_after: got e=%b v=%b req=%b want 1/0/1", empty_o, inst_valid_o, imem_req_o); end
    checks++;
    cyc(0, 0, 32'h0, 0, 0);
    if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL r_nostale: got %b want 0", inst_valid_o); end
    checks++;
  endtask

  task automatic test_gnt_stall;
    jmp_vld = 1'b1; jmp_pc = 32'h200;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 32'h0, 0, 0);
      if (pc_adv_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin errors++;
        $display("FAIL g_stall%0d: got adv=%b req=%b addr=%h want 0/1/200", i, pc_adv_o, imem_req_o, imem_addr_o); end
      checks++;
    end
    cyc(1, 0, 32'h0, 0, 0);
    if (pc_adv_o !== 1'b1 || imem_addr_o !== 32'h200) begin errors++;
      $display("FAIL g_grant: got adv=%b addr=%h want 1/200", pc_adv_o, imem_addr_o); end
    checks++;
    cyc(0, 0, 32'h0, 0, 0);
    if (pc_adv_o !== 1'b0 || imem_addr_o !== 32'h204) begin errors++;
      $display("FAIL g_once: got adv=%b addr=%h want 0/204", pc_adv_o, imem_addr_o); end
    checks++;
    cyc(0, 1, 32'hE000_0200, 1, 0);
    cyc(0, 0, 32'h0, 0, 0);
    if (inst_addr_o !== 32'h200 || inst_o !== 32'hE000_0200) begin errors++;
      $display("FAIL g_head: got a=%h d=%h want 200/e0000200", inst_addr_o, inst_o); end
    checks++;
    cyc(0, 0, 32'h0, 0, 0);
  endtask

  task automatic test_bypass;
    jmp_vld = 1'b1; jmp_pc = 32'h10;
    cyc(1, 0, 32'h0, 0, 0);
    cyc(0, 1, 32'h0050_0093, 0, 0);
    if (inst_valid_o !== BYP || inst_o !== (BYP ? 32'h0050_0093 : NOP) ||
        inst_addr_o !== (BYP ? 32'h10 : 32'h0)) begin errors++;
      $display("FAIL b_same: got v=%b d=%h a=%h want %b", inst_valid_o, inst_o, inst_addr_o, BYP); end
    checks++;
    cyc(0, 0, 32'h0, 0, 0);
    if (inst_valid_o !== !BYP || inst_addr_o !== (BYP ? 32'h0 : 32'h10) ||
        inst_o !== (BYP ? NOP : 32'h0050_0093)) begin errors++;
      $display("FAIL b_next: got v=%b d=%h a=%h want %b", inst_valid_o, inst_o, inst_addr_o, !BYP); end
    checks++;
    cyc(0, 0, 32'h0, 0, 0);
    if (empty_o !== 1'b1 || inst_valid_o !== 1'b0) begin errors++;
      $display("FAIL b_empty: got e=%b v=%b want 1/0", empty_o, inst_valid_o); end
    checks++;
  endtask

  initial begin
    test_reset;
    test_fetch_stream;
    test_hold_full;
    test_flush_outstanding;
    test_flush_with_rvalid;
    test_gnt_stall;
    test_bypass;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
